// File: rtl/sram_controller_pkg.sv
// Shared types and sizing for the SRAM controller: FSM states, SRAM bus widths
// and the number of 16-bit phases per read and write transfer.
package sram_controller_pkg;

    localparam int unsigned SRAM_AW      = 18;
    localparam int unsigned SRAM_DW      = 16;
    localparam int unsigned READ_PHASES  = 4;
    localparam int unsigned WRITE_PHASES = 2;
    localparam int unsigned PHASE_W      = 4;
    localparam int unsigned HW_W         = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sram_phase_counter.sv
// Phase / half-word sequencer: counts PHASE_CYCLES cycles per half-word access
// and advances the half-word index after the last cycle of each phase.
module sram_phase_counter
    import sram_controller_pkg::*;
#(
    parameter int unsigned PHASE_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            enable,
    output logic [HW_W-1:0] hw,
    output logic            last_phase
);

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(PHASE_CYCLES - 1);

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [HW_W-1:0]    hw_q, hw_d;

    assign hw         = hw_q;
    assign last_phase = (phase_q == LAST_PHASE);

    always_comb begin
        phase_d = phase_q;
        hw_d    = hw_q;
        if (clear) begin
            phase_d = '0;
            hw_d    = '0;
        end else if (enable) begin
            if (last_phase) begin
                phase_d = '0;
                hw_d    = hw_q + 1'b1;
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= '0;
            hw_q    <= '0;
        end else begin
            phase_q <= phase_d;
            hw_q    <= hw_d;
        end
    end

endmodule

// File: rtl/sram_controller.sv
// Cache-side SRAM controller: 64-bit block reads as four 16-bit accesses and
// 32-bit write-through as two 16-bit accesses on an asynchronous SRAM.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int unsigned PHASE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               read,
    input  logic               write,
    input  logic [31:0]        address,
    input  logic [31:0]        wdata,
    output logic [63:0]        rdata,
    output logic               ready,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N
);

    localparam logic [HW_W-1:0] READ_LAST_HW  = HW_W'(READ_PHASES - 1);
    localparam logic [HW_W-1:0] WRITE_LAST_HW = HW_W'(WRITE_PHASES - 1);

    state_t              state_q, state_d;
    logic [SRAM_AW-3:0]  addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [63:0]         rdata_q, rdata_d;

    logic [HW_W-1:0]     hw;
    logic                last_phase;
    logic                in_xfer;
    logic [SRAM_DW-1:0]  dq_out;
    logic                unused_addr_bits;

    // Only the SRAM-reachable word-address bits are kept.
    assign unused_addr_bits = ^{address[31:18], address[1:0]};

    assign in_xfer = (state_q == ST_READ) || (state_q == ST_WRITE);

    sram_phase_counter #(
        .PHASE_CYCLES (PHASE_CYCLES)
    ) u_phase (
        .clk        (clk),
        .rst        (rst),
        .clear      (!in_xfer),
        .enable     (in_xfer),
        .hw         (hw),
        .last_phase (last_phase)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (read || write) begin
                    addr_d  = address[17:2];
                    wdata_d = wdata;
                    state_d = read ? ST_READ : ST_WRITE;
                end
            end
            ST_READ: begin
                if (last_phase) begin
                    rdata_d[{hw, 4'b0000} +: SRAM_DW] = SRAM_DQ;
                    if (hw == READ_LAST_HW) state_d = ST_DONE;
                end
            end
            ST_WRITE: begin
                if (last_phase && (hw == WRITE_LAST_HW)) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        SRAM_ADDR = '0;
        SRAM_WE_N = 1'b1;
        dq_out    = wdata_q[{hw[0], 4'b0000} +: SRAM_DW];
        case (state_q)
            ST_READ:  SRAM_ADDR = {1'b0, addr_q[SRAM_AW-3:1], hw};
            ST_WRITE: begin
                SRAM_ADDR = {1'b0, addr_q, hw[0]};
                // WE_N rises on the final cycle so data/address hold past the strobe.
                SRAM_WE_N = last_phase;
            end
            default:  SRAM_ADDR = '0;
        endcase
    end

    assign SRAM_OE_N = (state_q != ST_READ);
    assign SRAM_CE_N = !in_xfer;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_DQ   = (state_q == ST_WRITE) ? dq_out : 'z;

    assign rdata = rdata_q;
    assign ready = ((state_q == ST_IDLE) && !read && !write) || (state_q == ST_DONE);

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have parameter PHASE_CYCLES, default 2: clock cycles per 16-bit SRAM access (legal range 2..15).
REQ-002 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port read, input, 1: 64-bit block read request from the cache controller.
REQ-005 SHALL have port write, input, 1: 32-bit write-through request from the cache controller.
REQ-006 SHALL have port address, input, 32: byte address of the request.
REQ-007 SHALL have port wdata, input, 32: write data.
REQ-008 SHALL have port rdata, output, 64: assembled block read data.
REQ-009 SHALL have port ready, output, 1: high when idle with no request, or when a transfer completes.
REQ-010 SHALL have port SRAM_DQ, inout, 16: SRAM data bus.
REQ-011 SHALL have port SRAM_ADDR, output, 18: SRAM half-word address.
REQ-012 SHALL have ports SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, each output, 1: active-low SRAM strobes.

Function
REQ-013 SHALL implement states IDLE, READ, WRITE, DONE.
REQ-014 In IDLE, read=1 SHALL move to READ; otherwise write=1 SHALL move to WRITE (read wins on simultaneous requests).
REQ-015 A request SHALL latch address[17:2] and wdata on the IDLE exit edge; later input changes SHALL be ignored until IDLE.
REQ-016 A 2-bit half-word index hw and a phase counter (0..PHASE_CYCLES-1) SHALL sequence every access.
REQ-017 READ SHALL perform 4 phases, hw=0..3, with SRAM_ADDR = {1'b0, addr[17:3], hw[1:0]}.
REQ-018 READ SHALL capture SRAM_DQ into rdata[16*hw+15 : 16*hw] on the last cycle of each phase.
REQ-019 WRITE SHALL perform 2 phases, hw=0..1, with SRAM_ADDR = {1'b0, addr[17:2], hw[0]}.
REQ-020 WRITE SHALL drive SRAM_DQ = wdata[16*hw+15 : 16*hw] for the whole phase.
REQ-021 During WRITE, SRAM_WE_N SHALL be 0 for the first PHASE_CYCLES-1 cycles of each phase and 1 on the last cycle.
REQ-022 SRAM_OE_N SHALL be 0 only in READ.
REQ-023 SRAM_CE_N SHALL be 0 only in READ or WRITE.
REQ-024 SRAM_UB_N and SRAM_LB_N SHALL be 0 constantly.
REQ-025 SRAM_DQ SHALL be high-impedance outside WRITE.
REQ-026 After the last phase, the FSM SHALL enter DONE for exactly one cycle, then return to IDLE.
REQ-027 ready SHALL equal (IDLE & !read & !write) | DONE, combinationally.
REQ-028 A request still asserted in the IDLE cycle after DONE SHALL start a new transfer.
REQ-029 Read latency SHALL be 4*PHASE_CYCLES+1 cycles from the request edge to ready; write latency SHALL be 2*PHASE_CYCLES+1.
REQ-030 rdata SHALL hold its last assembled value until the next READ overwrites it; WRITE SHALL NOT alter rdata.
REQ-031 SRAM_ADDR SHALL be 0 in IDLE and DONE.

Reset
REQ-032 rst=0 SHALL immediately force: state IDLE, counters 0, rdata 0, SRAM_ADDR 0, SRAM_WE_N/OE_N/CE_N 1, SRAM_DQ high-impedance.
REQ-033 Reset asserted mid-transfer SHALL abort the transfer with no DONE cycle and no further SRAM strobes.
REQ-034 After reset release, the first rising edge SHALL evaluate IDLE normally.

Structure
REQ-035 A shared package SHALL hold the state enum, SRAM address/data widths (18/16), and read/write phase counts (4/2).
REQ-036 The phase/half-word counter SHALL be one sub-module, sram_phase_counter, with inputs clear and enable and outputs hw and last_phase.
REQ-037 The FSM, bus drivers and rdata assembly SHALL remain in sram_controller.

Verification
REQ-038 Reset then idle SHALL give ready=1, CE_N=OE_N=WE_N=1, DQ=Z and rdata=0.
REQ-039 A read at address 0x0000_0108 with the SRAM model returning 0x1111, 0x2222, 0x3333, 0x4444 at half-words 0x84..0x87 SHALL give rdata=0x4444_3333_2222_1111 and ready high at cycle 9 (PHASE_CYCLES=2).
REQ-040 A write of 0xDEAD_BEEF to 0x0000_0010 SHALL produce half-word 0x8=0xBEEF and 0x9=0xDEAD, with ready at cycle 5 and rdata unchanged.
REQ-041 read=1 and write=1 asserted together SHALL execute the read first; the write SHALL start in the IDLE cycle after DONE if still held.
REQ-042 rst pulsed low during READ phase hw=2 SHALL give immediate IDLE with strobes high; a fresh read afterwards SHALL complete correctly.
REQ-043 With PHASE_CYCLES=3, a read SHALL give ready at cycle 13, and each write phase SHALL show WE_N low for 2 cycles then high for 1.
